// File: rtl/lat_dff_pkg.sv
// Shared mode encodings and force-source kinds for the LUXOR slice storage cell.
// Optional clock inversion is enabled with macro LAT_DFF_CLK_INV_EN.
package lat_dff_pkg;

    localparam logic MODE_FF  = 1'b0;
    localparam logic MODE_LAT = 1'b1;
    localparam logic SR_SYNC  = 1'b0;
    localparam logic SR_ASYNC = 1'b1;
    localparam logic SRVAL_LO = 1'b0;
    localparam logic SRVAL_HI = 1'b1;

    typedef enum logic [1:0] {
        FRC_NONE,
        FRC_RST,
        FRC_GSR,
        FRC_SR
    } force_e;

endpackage

// File: rtl/lat_dff_bit.sv
// Single-bit flop/latch cell built from a master latch (sampled controls) and a slave latch (Q).
// With LAT_DFF_CLK_INV_EN defined, CLK_INV=1 swaps the active edge/level of clk.
module lat_dff_bit
    import lat_dff_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic GSR,
    input  logic CE,
    input  logic D,
    input  logic SR,
    input  logic SYNCASYNC_01,
    input  logic FFLAT_01,
    input  logic INIT01,
    input  logic SRHILO,
`ifdef LAT_DFF_CLK_INV_EN
    input  logic CLK_INV,
`endif
    output logic Q
);

    logic   w_g;
    logic   w_lat;
    force_e w_frc;
    logic   r_m_d;
    logic   r_m_ce;
    logic   r_m_sr;
    logic   r_m_hilo;
    logic   r_q;

`ifdef LAT_DFF_CLK_INV_EN
    assign w_g = clk ^ CLK_INV;
`else
    assign w_g = clk;
`endif

    assign w_lat = (FFLAT_01 == MODE_LAT);

    always_comb begin
        w_frc = FRC_NONE;
        if (!rst_n)
            w_frc = FRC_RST;
        else if (GSR)
            w_frc = FRC_GSR;
        else if (SR && (SYNCASYNC_01 == SR_ASYNC))
            w_frc = FRC_SR;
    end

    // Master holds the update request, not Q itself, so Q never feeds back
    // through it; clearing it under force/latch mode stops a stale request
    // from re-loading D mid-phase after release or a mode switch.
    always_latch begin
        if ((w_frc != FRC_NONE) || w_lat) begin
            r_m_ce <= 1'b0;
            r_m_sr <= 1'b0;
        end else if (!w_g) begin
            r_m_d    <= D;
            r_m_ce   <= CE;
            r_m_sr   <= SR && (SYNCASYNC_01 == SR_SYNC);
            r_m_hilo <= SRHILO;
        end
    end

    always_latch begin
        case (w_frc)
            FRC_RST: r_q <= 1'b0;
            FRC_GSR: r_q <= INIT01;
            FRC_SR:  r_q <= SRHILO;
            default: begin
                if (w_g) begin
                    if (w_lat) begin
                        if (SR)
                            r_q <= SRHILO;
                        else if (CE)
                            r_q <= D;
                    end else begin
                        if (r_m_sr)
                            r_q <= r_m_hilo;
                        else if (r_m_ce)
                            r_q <= r_m_d;
                    end
                end
            end
        endcase
    end

    assign Q = r_q;

endmodule

// File: rtl/lat_dff.sv
// WIDTH-bit configurable flop/latch storage sharing clock, enables and configuration.
// Define LAT_DFF_CLK_INV_EN to add the CLK_INV polarity input.
module lat_dff
    import lat_dff_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             GSR,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic             SR,
    input  logic             SYNCASYNC_01,
    input  logic             FFLAT_01,
    input  logic             INIT01,
    input  logic             SRHILO,
`ifdef LAT_DFF_CLK_INV_EN
    input  logic             CLK_INV,
`endif
    output logic [WIDTH-1:0] Q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        lat_dff_bit u_bit (
            .clk          (clk),
            .rst_n        (rst_n),
            .GSR          (GSR),
            .CE           (CE),
            .D            (D[i]),
            .SR           (SR),
            .SYNCASYNC_01 (SYNCASYNC_01),
            .FFLAT_01     (FFLAT_01),
            .INIT01       (INIT01),
            .SRHILO       (SRHILO),
`ifdef LAT_DFF_CLK_INV_EN
            .CLK_INV      (CLK_INV),
`endif
            .Q            (Q[i])
        );
    end

endmodule

// File: tb/tb_lat_dff.sv
// Directed scoreboard bench for lat_dff (WIDTH=4): flop, latch, SR, GSR and reset priority.
module tb_lat_dff;

    logic       clk;
    logic       rst_n;
    logic       GSR;
    logic       CE;
    logic [3:0] D;
    logic       SR;
    logic       SYNCASYNC_01;
    logic       FFLAT_01;
    logic       INIT01;
    logic       SRHILO;
`ifdef LAT_DFF_CLK_INV_EN
    logic       CLK_INV;
`endif
    logic [3:0] Q;

    int         n_tests;
    int         n_fail;
    string      sb_tag[$];
    logic [3:0] sb_val[$];

    lat_dff #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .GSR          (GSR),
        .CE           (CE),
        .D            (D),
        .SR           (SR),
        .SYNCASYNC_01 (SYNCASYNC_01),
        .FFLAT_01     (FFLAT_01),
        .INIT01       (INIT01),
        .SRHILO       (SRHILO),
`ifdef LAT_DFF_CLK_INV_EN
        .CLK_INV      (CLK_INV),
`endif
        .Q            (Q)
    );

    task automatic push(input string tag, input logic [3:0] val);
        sb_tag.push_back(tag);
        sb_val.push_back(val);
    endtask

    task automatic check();
        string      t;
        logic [3:0] e;
        #1;
        n_tests++;
        if (sb_val.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected value queued, Q=%h", Q);
        end else begin
            t = sb_tag.pop_front();
            e = sb_val.pop_front();
            assert (Q === e) else begin
                n_fail++;
                $error("FAIL %s: Q=%h expected %h", t, Q, e);
            end
        end
    endtask

    task automatic clk_hi();
        #2 clk = 1'b1;
        #2;
    endtask

    task automatic clk_lo();
        #2 clk = 1'b0;
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk = 1'b0; rst_n = 1'b0; GSR = 1'b0; CE = 1'b0; D = 4'h0; SR = 1'b0;
        SYNCASYNC_01 = 1'b0; FFLAT_01 = 1'b0; INIT01 = 1'b0; SRHILO = 1'b0;
`ifdef LAT_DFF_CLK_INV_EN
        CLK_INV = 1'b0;
`endif
        #3;
        push("reset", 4'h0); check();
        rst_n = 1'b1; #2;

        // flop, synchronous SR
        CE = 1'b1; D = 4'hF;
        push("ff_capture", 4'hF); clk_hi(); check();
        clk_lo(); SR = 1'b1;
        push("ff_syncsr_wait", 4'hF); check();
        push("ff_syncsr_edge", 4'h0); clk_hi(); check();
        clk_lo(); SR = 1'b0;

        // flop, asynchronous SR
        SYNCASYNC_01 = 1'b1; SRHILO = 1'b1; #2;
        SR = 1'b1; push("ff_asyncsr_set", 4'hF); check();
        SR = 1'b0; push("ff_asyncsr_release", 4'hF); check();
        CE = 1'b0; D = 4'h0;
        push("ff_ce0_hold", 4'hF); clk_hi(); check();
        clk_lo();

        // latch mode
        FFLAT_01 = 1'b1; SYNCASYNC_01 = 1'b0; CE = 1'b1; D = 4'h0;
        push("lat_open_d0", 4'h0); clk_hi(); check();
        D = 4'hF; push("lat_track_d1", 4'hF); check();
        D = 4'h0; push("lat_track_d0", 4'h0); check();
        D = 4'hF; #1;
        push("lat_close", 4'hF); clk_lo(); check();
        D = 4'h0; push("lat_opaque_a", 4'hF); check();
        D = 4'h5; push("lat_opaque_b", 4'hF); check();
        SR = 1'b1; SRHILO = 1'b0;
        push("lat_syncsr_gate_low", 4'hF); check();
        push("lat_syncsr_gate_high", 4'h0); clk_hi(); check();
        SR = 1'b0; push("lat_sr_release_track", 4'h5); check();
        CE = 1'b0; D = 4'hA; push("lat_ce0_hold", 4'h5); check();
        clk_lo();

        // GSR mid-operation
        FFLAT_01 = 1'b0; CE = 1'b1; D = 4'h0;
        push("ff_load_zero", 4'h0); clk_hi(); check();
        clk_lo();
        SR = 1'b1; SRHILO = 1'b0; INIT01 = 1'b1; GSR = 1'b1;
        push("gsr_init1", 4'hF); check();
        INIT01 = 1'b0; push("gsr_init_follow0", 4'h0); check();
        INIT01 = 1'b1; #1;
        GSR = 1'b0; push("gsr_release_hold", 4'hF); check();
        push("gsr_then_syncsr", 4'h0); clk_hi(); check();
        clk_lo(); SR = 1'b0;

        // rst_n over GSR
        GSR = 1'b1; INIT01 = 1'b1; #1;
        rst_n = 1'b0; push("rst_over_gsr", 4'h0); check();
        rst_n = 1'b1; push("rst_release_gsr", 4'hF); check();
        GSR = 1'b0; push("gsr_release", 4'hF); check();
        CE = 1'b0; push("gsr_edge_ce0", 4'hF); clk_hi(); check();
        clk_lo();

        // multi-bit flop, CE gating and SR overriding CE
        rst_n = 1'b0; #1; rst_n = 1'b1;
        CE = 1'b0; D = 4'hA;
        push("w4_ce0_edge", 4'h0); clk_hi(); check();
        clk_lo(); CE = 1'b1;
        push("w4_ce1_edge", 4'hA); clk_hi(); check();
        clk_lo(); SR = 1'b1; SRHILO = 1'b1;
        push("w4_syncsr_set", 4'hF); clk_hi(); check();
        clk_lo(); CE = 1'b0; SRHILO = 1'b0;
        push("w4_sr_over_ce0", 4'h0); clk_hi(); check();
        clk_lo(); SR = 1'b0;

        // mode switches keep Q
        FFLAT_01 = 1'b1; push("sw_ff_to_lat", 4'h0); check();
        CE = 1'b1; D = 4'h3;
        push("sw_lat_load", 4'h3); clk_hi(); check();
        FFLAT_01 = 1'b0; D = 4'hC;
        push("sw_lat_to_ff_hold", 4'h3); check();
        clk_lo();
        push("sw_ff_edge", 4'hC); clk_hi(); check();
        clk_lo();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
